// File: rtl/inst_fetch_queue_pkg.sv
// Shared instruction-path definitions: word width, NOP encoding and default prefetch depth.
package inst_fetch_queue_pkg;

  localparam int              INST_WIDTH  = 16;
  localparam logic [15:0]     INST_NOP    = 16'h0000;
  localparam int              QUEUE_DEPTH = 4;

endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Queue storage: DEPTH x WIDTH registers, clocked write port, combinational read port, no reset.
module inst_queue_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; 1-cycle fill latency, first-word fall-through.
// Fetch is stalled while full (in_ready=0); decode's out_ready is ignored while empty.
import inst_fetch_queue_pkg::*;

module inst_fetch_queue #(
  parameter int WIDTH = INST_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push;
  logic             pop;

  // Status comes only from the registered count, so no input reaches these flags.
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  inst_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push & !flush & !reset),
    .waddr (wr_ptr),
    .wdata (in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out = out_valid ? rdata : WIDTH'(INST_NOP);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised + directed bench for inst_fetch_queue; a queue-based reference model feeds a negedge scoreboard.
module tb_inst_fetch_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  bit          room = 1'b1;
  logic [15:0] exp_q[$];

  inst_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words; reset/flush empties it, an offered word enters only if there was room.
  always @(posedge clock) begin
    if (reset || flush) exp_q.delete();
    else if (in_valid && room) exp_q.push_back(in);
  end

  // Scoreboard: flags from model occupancy; head word compared and retired when decode takes it.
  always @(negedge clock) begin
    if (mon_en) begin
      int n;
      n = exp_q.size();
      chk("count",     32'(count),     32'(n));
      chk("empty",     32'(empty),     32'(n == 0));
      chk("full",      32'(full),      32'(n == DEPTH));
      chk("in_ready",  32'(in_ready),  32'(n < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(n > 0));
      if (n == 0) chk("out_idle_zero", 32'(out), 32'h0);
      if (out_valid && !reset) begin
        if (n == 0) chk("unexpected_out", 32'(out), 32'hFFFF_FFFF);
        else begin
          chk("out_data", 32'(out), 32'(exp_q[0]));
          if (out === 16'hBEEF) chk("dropped_word_seen", 32'(out), 32'h0);
        end
      end
      room = (n < DEPTH);
      if (out_valid && out_ready && n > 0) void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit r, input bit f, input bit v, input logic [15:0] d, input bit o);
    reset = r; flush = f; in_valid = v; in = d; out_ready = o;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: reset for two cycles, then idle
    step(1, 0, 0, 16'h0, 0);
    mon_en = 1'b1;
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_empty", 32'(empty), 32'h1);

    // 2: fill, over-push ignored, drain in order
    step(0, 0, 1, 16'h1111, 0);
    step(0, 0, 1, 16'h2222, 0);
    step(0, 0, 1, 16'h3333, 0);
    step(0, 0, 1, 16'h4444, 0);
    chk("full_after_4", 32'(full), 32'h1);
    step(0, 0, 1, 16'hDEAD, 0);
    chk("no_overwrite_count", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    chk("drained_empty", 32'(empty), 32'h1);

    // 3: 3 deep, then simultaneous push/pop streaming through the wrap
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0100 + 16'(i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 16'h0200 + 16'(i), 1);
    chk("stream_count", 32'(count), 32'h3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 1);

    // 4: flush with concurrent push and pop
    step(0, 0, 1, 16'hC001, 0);
    step(0, 0, 1, 16'hC002, 0);
    step(0, 1, 1, 16'hBEEF, 1);
    step(0, 0, 0, 16'h0, 1);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_out", 32'(out), 32'h0);

    // 5: push into empty queue with out_ready high, no bypass
    step(0, 0, 1, 16'hA5A5, 1);
    chk("a5_visible", 32'(out), 32'hA5A5);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);

    // 6: reset while full with a word offered
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h7000 + 16'(i), 0);
    step(1, 0, 1, 16'h7777, 1);
    step(0, 0, 0, 16'h0, 0);
    chk("reset_full_count", 32'(count), 32'h0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 16'h0, 1);
    chk("final_empty", 32'(empty), 32'h1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
